// File: rtl/prefetch_ctrl.sv
// Instruction prefetch request generator. Tracks the linear fetch pointer and the
// bytes remaining before the CS limit, issues page/limit-clipped icache read requests,
// throttles on prefetch FIFO occupancy and signals a one-shot limit event.
module prefetch_ctrl #(
   parameter int unsigned FIFO_USED_W     = 5,
   parameter int unsigned FIFO_HIGH_WATER = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pr_reset,
   input  logic [31:0]            restart_eip,
   input  logic [31:0]            cs_base,
   input  logic [31:0]            cs_limit,
   input  logic                   cache_disable_in,
   input  logic [FIFO_USED_W-1:0] prefetchfifo_used,
   output logic                   icacheread_do,
   output logic [31:0]            icacheread_address,
   output logic [4:0]             icacheread_length,
   output logic                   icacheread_cache_disable,
   input  logic                   prefetched_do,
   input  logic [4:0]             prefetched_length,
   output logic                   limit_signal_do
);

   localparam logic [FIFO_USED_W:0] HighWater = FIFO_HIGH_WATER[FIFO_USED_W:0];

   typedef enum logic {StStopped = 1'b0, StRun = 1'b1} state_t;

   state_t      state;
   logic [31:0] lin_addr;
   logic [32:0] limit_rem;   // 33 bits: eip=0 with limit=FFFFFFFF leaves 2^32 bytes
   logic        limit_sent;

   logic [12:0] page_rem;
   logic [4:0]  len_page;
   logic [32:0] ack_len;

   assign ack_len = {28'd0, prefetched_length};

   // Request length: never crosses a 4 KB page or the CS limit, capped at 16 bytes.
   always_comb begin
      page_rem          = 13'd4096 - {1'b0, lin_addr[11:0]};
      len_page          = (page_rem < 13'd16) ? page_rem[4:0] : 5'd16;
      icacheread_length = (limit_rem < {28'd0, len_page}) ? limit_rem[4:0] : len_page;
   end

   // Request valid and pass-through outputs.
   always_comb begin
      icacheread_do = (state == StRun) && !pr_reset && (limit_rem != 33'd0) &&
                      ({1'b0, prefetchfifo_used} < HighWater);
      icacheread_address       = lin_addr;
      icacheread_cache_disable = cache_disable_in;
   end

   // Fetch pointer, limit accounting and RUN/STOPPED control; pr_reset beats acks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= StStopped;
         lin_addr        <= 32'd0;
         limit_rem       <= 33'd0;
         limit_sent      <= 1'b0;
         limit_signal_do <= 1'b0;
      end else if (pr_reset) begin
         state           <= StRun;
         lin_addr        <= cs_base + restart_eip;
         limit_rem       <= (restart_eip > cs_limit) ? 33'd0 :
                            {1'b0, cs_limit} - {1'b0, restart_eip} + 33'd1;
         limit_sent      <= 1'b0;
         limit_signal_do <= 1'b0;
      end else begin
         limit_signal_do <= 1'b0;
         if (state == StRun) begin
            if (prefetched_do) begin
               lin_addr  <= lin_addr + {27'd0, prefetched_length};
               // Over-delivery past the limit is a protocol error; saturate rather than wrap.
               limit_rem <= (ack_len > limit_rem) ? 33'd0 : limit_rem - ack_len;
            end
            if ((limit_rem == 33'd0) && !limit_sent) begin
               limit_signal_do <= 1'b1;
               limit_sent      <= 1'b1;
               state           <= StStopped;
            end
         end
      end
   end

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Self-checking bench for prefetch_ctrl: expected output vectors are pushed to a
// scoreboard queue as stimulus is applied and popped when the outputs are sampled.
module tb_prefetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        pr_reset;
   logic [31:0] restart_eip;
   logic [31:0] cs_base;
   logic [31:0] cs_limit;
   logic        cache_disable_in;
   logic [4:0]  prefetchfifo_used;
   logic        icacheread_do;
   logic [31:0] icacheread_address;
   logic [4:0]  icacheread_length;
   logic        icacheread_cache_disable;
   logic        prefetched_do;
   logic [4:0]  prefetched_length;
   logic        limit_signal_do;

   int checks   = 0;
   int failures = 0;

   // Vector layout: {do, address, length, limit_signal}
   typedef struct {
      string       name;
      logic [38:0] v;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [38:0] obs;

   prefetch_ctrl #(
      .FIFO_USED_W    (5),
      .FIFO_HIGH_WATER(12)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .pr_reset                (pr_reset),
      .restart_eip             (restart_eip),
      .cs_base                 (cs_base),
      .cs_limit                (cs_limit),
      .cache_disable_in        (cache_disable_in),
      .prefetchfifo_used       (prefetchfifo_used),
      .icacheread_do           (icacheread_do),
      .icacheread_address      (icacheread_address),
      .icacheread_length       (icacheread_length),
      .icacheread_cache_disable(icacheread_cache_disable),
      .prefetched_do           (prefetched_do),
      .prefetched_length       (prefetched_length),
      .limit_signal_do         (limit_signal_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [38:0] outs();
      return {icacheread_do, icacheread_address, icacheread_length, limit_signal_do};
   endfunction

   task automatic push(input string name, input logic d, input logic [31:0] a,
                       input logic [4:0] l, input logic lim);
      exp_t x;
      x.name = name;
      x.v    = {d, a, l, lim};
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic [31:0] base, input logic [31:0] eip,
                          input logic [31:0] lim);
      pr_reset    = 1'b1;
      cs_base     = base;
      restart_eip = eip;
      cs_limit    = lim;
      tick();
      pr_reset = 1'b0;
      #1;
   endtask

   task automatic ack(input logic [4:0] len);
      prefetched_do     = 1'b1;
      prefetched_length = len;
      tick();
      prefetched_do = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      #2;
      push("reset_outputs", 1'b0, 32'h0, 5'd0, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push("idle_after_reset", 1'b0, 32'h0, 5'd0, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
   endtask

   task automatic test_page_clip();
      restart(32'h1000, 32'h0FF8, 32'hFFFF);
      push("page_clip", 1'b1, 32'h1FF8, 5'd8, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      cache_disable_in = 1'b1;
      #1;
      checks++;
      if (icacheread_cache_disable !== 1'b1) begin
         failures++; $display("FAIL cache_disable got=%b want=1", icacheread_cache_disable);
      end
      cache_disable_in = 1'b0;
      ack(5'd8);
      push("next_page", 1'b1, 32'h2000, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
   endtask

   task automatic test_limit();
      int pulses;
      restart(32'h0, 32'hFFF4, 32'hFFFF);
      push("limit_len", 1'b1, 32'hFFF4, 5'd12, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      ack(5'd12);
      push("limit_reached", 1'b0, 32'h10000, 5'd0, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      tick();
      push("limit_pulse", 1'b0, 32'h10000, 5'd0, 1'b1);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (limit_signal_do === 1'b1 || icacheread_do !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++; $display("FAIL limit_no_repeat got=%0d want=0", pulses);
      end
      // Limit tighter than the page and the 16-byte cap.
      restart(32'h100, 32'hFFF0, 32'hFFF9);
      push("limit_clip", 1'b1, 32'h100F0, 5'd10, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
   endtask

   task automatic test_over_limit();
      int pulses;
      int reqs;
      restart(32'h0, 32'h20000, 32'hFFFF);
      push("over_limit_first", 1'b0, 32'h20000, 5'd0, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      tick();
      push("over_limit_pulse", 1'b0, 32'h20000, 5'd0, 1'b1);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      pulses = 0;
      reqs   = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (limit_signal_do === 1'b1) pulses++;
         if (icacheread_do !== 1'b0) reqs++;
      end
      checks++;
      if (pulses + reqs !== 0) begin
         failures++; $display("FAIL over_limit_quiet got=%0d want=0", pulses + reqs);
      end
   endtask

   task automatic test_long_run();
      int pulses;
      restart(32'h0, 32'h0, 32'hFFFF_FFFF);
      pulses            = 0;
      prefetched_do     = 1'b1;
      prefetched_length = 5'd16;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (limit_signal_do === 1'b1) pulses++;
      end
      prefetched_do = 1'b0;
      #1;
      push("long_run", 1'b1, 32'h12C0, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      checks++;
      if (pulses !== 0) begin
         failures++; $display("FAIL long_run_no_limit got=%0d want=0", pulses);
      end
      restart(32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFFF);
      ack(5'd16);
      push("addr_wrap", 1'b1, 32'h0, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      ack(5'd8);
      push("after_wrap", 1'b1, 32'h8, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
   endtask

   task automatic test_throttle();
      restart(32'h0, 32'h100, 32'hFFFF);
      prefetchfifo_used = 5'd12;
      #1;
      push("throttle_at_hw", 1'b0, 32'h100, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      prefetchfifo_used = 5'd11;
      #1;
      push("below_hw", 1'b1, 32'h100, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      prefetchfifo_used = 5'd31;
      ack(5'd4);
      push("ack_while_throttled", 1'b0, 32'h104, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      prefetchfifo_used = 5'd0;
      #1;
   endtask

   task automatic test_back_to_back();
      restart(32'h0, 32'h40, 32'hFFFF);
      pr_reset          = 1'b1;
      cs_base           = 32'h3000;
      restart_eip       = 32'h10;
      prefetched_do     = 1'b1;
      prefetched_length = 5'd16;
      tick();
      pr_reset      = 1'b0;
      prefetched_do = 1'b0;
      #1;
      push("pr_reset_priority", 1'b1, 32'h3010, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      ack(5'd16);
      #2;
      rst_n = 1'b0;
      #1;
      push("async_reset", 1'b0, 32'h0, 5'd0, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      pr_reset    = 1'b1;
      cs_base     = 32'h500;
      restart_eip = 32'h20;
      tick();
      push("reset_beats_pr_reset", 1'b0, 32'h0, 5'd0, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push("pr_reset_after_deassert", 1'b0, 32'h520, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
      pr_reset = 1'b0;
      #1;
      push("run_after_deassert", 1'b1, 32'h520, 5'd16, 1'b0);
      obs = outs(); e = sb.pop_front(); checks++;
      if (obs !== e.v) begin
         failures++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v);
      end
   endtask

   initial begin
      rst_n             = 1'b0;
      pr_reset          = 1'b0;
      restart_eip       = 32'h0;
      cs_base           = 32'h0;
      cs_limit          = 32'h0;
      cache_disable_in  = 1'b0;
      prefetchfifo_used = 5'd0;
      prefetched_do     = 1'b0;
      prefetched_length = 5'd0;
      test_reset();
      test_page_clip();
      test_limit();
      test_over_limit();
      test_long_run();
      test_throttle();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
